// File: rtl/turn_timer_ctrl_if.sv
// Panel-side and display-side signals of the turn timer, bundled for the controller port.
// The panel drives the controls; the controller drives the digits, LEDs and status.
interface turn_timer_ctrl_if;
    logic       start;
    logic       pause;
    logic       end_turn;
    logic       abort;
    logic [1:0] dozens;
    logic [3:0] units;
    logic       player;
    logic       running;
    logic       timeout;
    logic [7:0] turn_count;

    modport master (
        output start, pause, end_turn, abort,
        input  dozens, units, player, running, timeout, turn_count
    );

    modport slave (
        input  start, pause, end_turn, abort,
        output dozens, units, player, running, timeout, turn_count
    );
endinterface

// File: rtl/turn_timer_ctrl.sv
// Two-player BCD turn countdown: 1 Hz prescaler, reload/count-down of dozens:units,
// player alternation and start/pause/end-turn/abort sequencing. All outputs registered.
module turn_timer_ctrl #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned TURN_DOZENS = 3,
    parameter int unsigned TURN_UNITS  = 0
) (
    input  logic             clock,
    input  logic             reset,
    turn_timer_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
    localparam logic [1:0] ReloadDozens = 2'(TURN_DOZENS);
    localparam logic [3:0] ReloadUnits  = 4'(TURN_UNITS);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StSwitch} state_e;

    state_e        state_q;
    logic [PW-1:0] prescaler_q;
    logic          tick;
    logic          last_second;

    assign tick        = (prescaler_q == TickLast);
    assign last_second = (bus.dozens == 2'd0) && (bus.units == 4'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            prescaler_q    <= '0;
            bus.dozens     <= ReloadDozens;
            bus.units      <= ReloadUnits;
            bus.player     <= 1'b0;
            bus.running    <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.turn_count <= 8'd0;
        end else begin
            bus.timeout <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bus.dozens  <= ReloadDozens;
                    bus.units   <= ReloadUnits;
                    prescaler_q <= '0;
                    bus.player  <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state_q        <= StRun;
                        bus.running    <= 1'b1;
                        bus.turn_count <= 8'd0;
                    end
                end
                StRun, StPause: begin
                    if (bus.abort) begin
                        state_q     <= StIdle;
                        bus.running <= 1'b0;
                        prescaler_q <= '0;
                        bus.player  <= 1'b0;
                        bus.dozens  <= ReloadDozens;
                        bus.units   <= ReloadUnits;
                    end else if (bus.end_turn) begin
                        state_q     <= StSwitch;
                        bus.running <= 1'b0;
                    end else if (bus.pause) begin
                        state_q     <= StPause;
                        bus.running <= 1'b0;
                    end else if (state_q == StPause) begin
                        // Leaving pause costs no prescaler phase; counting resumes next edge.
                        state_q     <= StRun;
                        bus.running <= 1'b1;
                    end else if (tick) begin
                        prescaler_q <= '0;
                        if (bus.units != 4'd0) begin
                            bus.units <= bus.units - 4'd1;
                        end else if (bus.dozens != 2'd0) begin
                            bus.units  <= 4'd9;
                            bus.dozens <= bus.dozens - 2'd1;
                        end
                        if (last_second) begin
                            state_q     <= StSwitch;
                            bus.running <= 1'b0;
                            bus.timeout <= 1'b1;
                        end
                    end else begin
                        prescaler_q <= prescaler_q + 1'b1;
                    end
                end
                StSwitch: begin
                    prescaler_q <= '0;
                    bus.dozens  <= ReloadDozens;
                    bus.units   <= ReloadUnits;
                    if (bus.abort) begin
                        state_q    <= StIdle;
                        bus.player <= 1'b0;
                    end else begin
                        state_q     <= StRun;
                        bus.running <= 1'b1;
                        bus.player  <= ~bus.player;
                        if (bus.turn_count != 8'hFF) begin
                            bus.turn_count <= bus.turn_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    bus.running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Directed, table-driven bench for turn_timer_ctrl with TICK_DIV=4 and reload 3:0,
// plus hand-written sequences for pause/end-turn overlap, abort in PAUSE and saturation.
module tb_turn_timer_ctrl;
    logic clock;
    logic reset;
    int   passed;
    int   total;

    turn_timer_ctrl_if bus_if ();

    turn_timer_ctrl #(
        .TICK_DIV    (4),
        .TURN_DOZENS (3),
        .TURN_UNITS  (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst, st, pa, et, ab;
        int         cyc;
        logic [1:0] d;
        logic [3:0] u;
        logic       pl, run, to;
        logic [7:0] tc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rst, input int st, input int pa, input int et, input int ab,
                       input int cyc, input int d, input int u, input int pl, input int run,
                       input int to, input int tc);
        vec_t v;
        v.rst = (rst != 0); v.st = (st != 0); v.pa = (pa != 0);
        v.et  = (et != 0);  v.ab = (ab != 0); v.cyc = cyc;
        v.d = 2'(d); v.u = 4'(u); v.pl = (pl != 0); v.run = (run != 0);
        v.to = (to != 0); v.tc = 8'(tc);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic pa, input logic et, input logic ab);
        bus_if.start = st; bus_if.pause = pa; bus_if.end_turn = et; bus_if.abort = ab;
    endtask

    task automatic check_all(input string tag, input int d, input int u, input int pl,
                             input int run, input int to, input int tc);
        check({tag, " dozens"}, int'(bus_if.dozens), d);
        check({tag, " units"}, int'(bus_if.units), u);
        check({tag, " player"}, int'(bus_if.player), pl);
        check({tag, " running"}, int'(bus_if.running), run);
        check({tag, " timeout"}, int'(bus_if.timeout), to);
        check({tag, " turn_count"}, int'(bus_if.turn_count), tc);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //  rst st pa et ab cyc  d  u pl run to tc
        add(1, 0, 0, 0, 0,   2, 3, 0, 0, 0, 0, 0);  // reset state
        add(0, 0, 1, 1, 0,   2, 3, 0, 0, 0, 0, 0);  // pause/end_turn ignored in IDLE
        add(0, 1, 0, 0, 0,   1, 3, 0, 0, 1, 0, 0);  // start
        add(0, 0, 0, 0, 0,   4, 2, 9, 0, 1, 0, 0);  // first tick after 4 cycles
        add(0, 0, 0, 0, 0,  16, 2, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,   2, 2, 5, 0, 1, 0, 0);  // prescaler phase 2
        add(0, 0, 1, 0, 0,  10, 2, 5, 0, 0, 0, 0);  // paused, frozen
        add(0, 0, 0, 0, 0,   1, 2, 5, 0, 1, 0, 0);  // resume, phase still 2
        add(0, 0, 0, 0, 0,   1, 2, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,   1, 2, 4, 0, 1, 0, 0);  // tick after 4 RUN edges total
        add(0, 0, 0, 0, 0,  28, 1, 7, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0,   1, 1, 7, 0, 0, 0, 0);  // end_turn: SWITCH shows 1:7
        add(0, 0, 0, 0, 0,   1, 3, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 119, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1, 1);  // expiry: 0:0 with timeout
        add(0, 0, 0, 0, 0,   1, 3, 0, 0, 1, 0, 2);  // timeout was one cycle only
        add(0, 0, 0, 0, 0,   6, 2, 9, 0, 1, 0, 2);
        add(0, 0, 0, 1, 1,   1, 3, 0, 0, 0, 0, 2);  // abort beats end_turn, count held
        add(0, 1, 0, 0, 0,   1, 3, 0, 0, 1, 0, 0);  // restart clears count
        add(0, 0, 0, 0, 0,   5, 2, 9, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0);  // reset mid-RUN

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            drive(vecs[i].st, vecs[i].pa, vecs[i].et, vecs[i].ab);
            step(vecs[i].cyc);
            check_all($sformatf("v%0d", i), vecs[i].d, vecs[i].u, vecs[i].pl,
                      vecs[i].run, vecs[i].to, vecs[i].tc);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // end_turn and pause together in RUN, pause held through SWITCH, then abort in PAUSE
        drive(1'b1, 1'b0, 1'b0, 1'b0); step(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); step(3);
        drive(1'b0, 1'b1, 1'b1, 1'b0); step(1);
        check_all("et+pause switch", 3, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0); step(1);
        check_all("switch to run", 3, 0, 1, 1, 0, 1);
        step(1);
        check_all("run to pause", 3, 0, 1, 0, 0, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1); step(1);
        check_all("abort in pause", 3, 0, 0, 0, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); step(1);

        // 260 end_turn pulses: player parity and saturation at 255
        drive(1'b1, 1'b0, 1'b0, 1'b0); step(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 260; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0); step(1);
            check($sformatf("pulse%0d switch running", i), int'(bus_if.running), 0);
            drive(1'b0, 1'b0, 1'b0, 1'b0); step(1);
            check($sformatf("pulse%0d player", i), int'(bus_if.player), i % 2);
            check($sformatf("pulse%0d turn_count", i), int'(bus_if.turn_count),
                  (i > 255) ? 255 : i);
        end
        check("sat digits", {28'd0, bus_if.units} + 10 * {30'd0, bus_if.dozens}, 30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
